// File: rtl/wts_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wts_pkg : shared constants and types for the wavetable RAM      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package wts_pkg;

   localparam int WTS_CH_NUM    = 12;
   localparam int WTS_WAVE_LEN  = 32;
   localparam int WTS_RAM_WORDS = WTS_CH_NUM * WTS_WAVE_LEN;

   typedef logic [8:0] wts_addr_t;
   typedef logic [7:0] wts_data_t;

   typedef enum logic [0:0] {
      DST_CPU = 1'b0,
      DST_SND = 1'b1
   } wts_dst_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_SND  = 2'd1,
      GNT_CPU  = 2'd2
   } wts_gnt_e;

   // Wave length is 32, so ch*32 + idx is simply the concatenation.
   function automatic wts_addr_t snd_addr(input logic [3:0] ch, input logic [4:0] idx);
      return {ch, idx};
   endfunction

endpackage
`default_nettype wire

// File: rtl/wts_ram_ctrl_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wts_ram_ctrl_if : CPU, tone-generator and SRAM port bundle      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface wts_ram_ctrl_if;
   import wts_pkg::*;

   logic       cpu_req;
   logic       cpu_wr;
   wts_addr_t  cpu_a;
   wts_data_t  cpu_d;
   logic       cpu_ack;
   wts_data_t  cpu_q;
   logic       cpu_q_valid;

   logic       snd_req;
   logic [3:0] snd_ch;
   logic [4:0] snd_idx;
   logic       snd_ack;
   wts_data_t  snd_q;
   logic       snd_q_valid;

   logic       sram_we;
   wts_addr_t  sram_a;
   wts_data_t  sram_d;
   wts_data_t  sram_q;

   modport slave (
      input  cpu_req, cpu_wr, cpu_a, cpu_d, snd_req, snd_ch, snd_idx, sram_q,
      output cpu_ack, cpu_q, cpu_q_valid, snd_ack, snd_q, snd_q_valid,
             sram_we, sram_a, sram_d
   );

   modport master (
      output cpu_req, cpu_wr, cpu_a, cpu_d, snd_req, snd_ch, snd_idx, sram_q,
      input  cpu_ack, cpu_q, cpu_q_valid, snd_ack, snd_q, snd_q_valid,
             sram_we, sram_a, sram_d
   );

endinterface
`default_nettype wire

// File: rtl/wts_ram_rdpipe.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wts_ram_rdpipe : two-stage read return path and data capture    |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module wts_ram_rdpipe
   import wts_pkg::*;
(
   input  wire logic      clk,
   input  wire logic      nreset,
   input  wire logic      issue_vld,
   input  wire wts_dst_e  issue_dst,
   input  wire logic      issue_oor,
   input  wire wts_data_t sram_q,
   output wts_data_t      cpu_q,
   output logic           cpu_q_valid,
   output wts_data_t      snd_q,
   output logic           snd_q_valid
);

   logic     r_vld1, r_vld2;
   wts_dst_e r_dst1, r_dst2;
   logic     r_oor1, r_oor2;

   // Stage 2 lines up with sram_q carrying the data for its address.
   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_vld1      <= 1'b0;
         r_vld2      <= 1'b0;
         r_dst1      <= DST_CPU;
         r_dst2      <= DST_CPU;
         r_oor1      <= 1'b0;
         r_oor2      <= 1'b0;
         cpu_q       <= '0;
         snd_q       <= '0;
         cpu_q_valid <= 1'b0;
         snd_q_valid <= 1'b0;
      end else begin
         r_vld1      <= issue_vld;
         r_dst1      <= issue_dst;
         r_oor1      <= issue_oor;
         r_vld2      <= r_vld1;
         r_dst2      <= r_dst1;
         r_oor2      <= r_oor1;
         cpu_q_valid <= r_vld2 && (r_dst2 == DST_CPU);
         snd_q_valid <= r_vld2 && (r_dst2 == DST_SND);
         if (r_vld2 && (r_dst2 == DST_CPU)) begin
            cpu_q <= r_oor2 ? 8'hFF : sram_q;
         end
         if (r_vld2 && (r_dst2 == DST_SND)) begin
            snd_q <= r_oor2 ? 8'h00 : sram_q;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/wts_ram_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | wts_ram_ctrl : CPU / tone-generator arbiter for the wavetable RAM|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module wts_ram_ctrl
   import wts_pkg::*;
#(
   parameter int RAM_WORDS     = WTS_RAM_WORDS,
   parameter int SND_BURST_MAX = 2
) (
   input  wire logic      clk,
   input  wire logic      nreset,
   wts_ram_ctrl_if.slave  bus
);

   localparam int               c_CNT_W     = (SND_BURST_MAX < 1) ? 1 : $clog2(SND_BURST_MAX + 1);
   localparam logic [c_CNT_W-1:0] c_BURST_MAX = c_CNT_W'(SND_BURST_MAX);
   localparam logic [9:0]       c_RAM_LIMIT = 10'(RAM_WORDS);
   localparam logic [3:0]       c_CH_NUM    = 4'(WTS_CH_NUM);

   logic               r_cpu_ack;
   logic               r_snd_ack;
   logic               r_we;
   wts_addr_t          r_a;
   wts_data_t          r_d;
   logic [c_CNT_W-1:0] r_burst;

   wts_gnt_e  w_gnt;
   logic      w_cpu_turn;
   logic      w_cpu_oor;
   logic      w_snd_oor;
   wts_addr_t w_snd_a;
   logic      w_issue_vld;
   wts_dst_e  w_issue_dst;
   logic      w_issue_oor;

   // Sound owns the slot unless the CPU has already waited out a full burst.
   // A requester whose ack is high this cycle is not eligible again yet.
   always_comb begin
      w_gnt       = GNT_NONE;
      w_cpu_turn  = bus.cpu_req && (r_burst == c_BURST_MAX);
      w_cpu_oor   = ({1'b0, bus.cpu_a} >= c_RAM_LIMIT);
      w_snd_oor   = (bus.snd_ch >= c_CH_NUM);
      w_snd_a     = snd_addr(bus.snd_ch, bus.snd_idx);
      if (bus.snd_req && !w_cpu_turn) begin
         if (!r_snd_ack) begin
            w_gnt = GNT_SND;
         end
      end else if (bus.cpu_req && !r_cpu_ack) begin
         w_gnt = GNT_CPU;
      end
      w_issue_vld = (w_gnt == GNT_SND) || ((w_gnt == GNT_CPU) && !bus.cpu_wr);
      w_issue_dst = (w_gnt == GNT_SND) ? DST_SND : DST_CPU;
      w_issue_oor = (w_gnt == GNT_SND) ? w_snd_oor : w_cpu_oor;
   end

   always_ff @(posedge clk) begin
      if (!nreset) begin
         r_cpu_ack <= 1'b0;
         r_snd_ack <= 1'b0;
         r_we      <= 1'b0;
         r_a       <= '0;
         r_d       <= '0;
         r_burst   <= '0;
      end else begin
         r_cpu_ack <= (w_gnt == GNT_CPU);
         r_snd_ack <= (w_gnt == GNT_SND);
         r_we      <= (w_gnt == GNT_CPU) && bus.cpu_wr && !w_cpu_oor;
         if (w_gnt == GNT_CPU) begin
            r_a <= bus.cpu_a;
            r_d <= bus.cpu_d;
         end else if (w_gnt == GNT_SND) begin
            r_a <= w_snd_a;
         end
         if (!bus.cpu_req || (w_gnt == GNT_CPU)) begin
            r_burst <= '0;
         end else if (w_gnt == GNT_SND) begin
            r_burst <= r_burst + 1'b1;
         end
      end
   end

   assign bus.cpu_ack = r_cpu_ack;
   assign bus.snd_ack = r_snd_ack;
   assign bus.sram_we = r_we;
   assign bus.sram_a  = r_a;
   assign bus.sram_d  = r_d;

   wts_ram_rdpipe u_rdpipe (
      .clk         (clk),
      .nreset      (nreset),
      .issue_vld   (w_issue_vld),
      .issue_dst   (w_issue_dst),
      .issue_oor   (w_issue_oor),
      .sram_q      (bus.sram_q),
      .cpu_q       (bus.cpu_q),
      .cpu_q_valid (bus.cpu_q_valid),
      .snd_q       (bus.snd_q),
      .snd_q_valid (bus.snd_q_valid)
   );

endmodule
`default_nettype wire

// File: tb/tb_wts_ram_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------+
// | tb_wts_ram_ctrl : self-checking bench with reference model      |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_wts_ram_ctrl;
   import wts_pkg::*;

   localparam int BURST = 2;

   logic clk    = 1'b0;
   logic nreset = 1'b0;
   always #5 clk = ~clk;

   wts_ram_ctrl_if bus_if ();

   wts_ram_ctrl #(
      .RAM_WORDS     (WTS_RAM_WORDS),
      .SND_BURST_MAX (BURST)
   ) dut (
      .clk    (clk),
      .nreset (nreset),
      .bus    (bus_if.slave)
   );

   // Synchronous RAM: data for the address appears one clock later.
   logic [7:0] ram [512];
   always @(posedge clk) begin
      if (bus_if.sram_we) ram[bus_if.sram_a] <= bus_if.sram_d;
      bus_if.sram_q <= ram[bus_if.sram_a];
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int due;
      bit snd;
      int data;
   } rd_t;

   rd_t rdq [$];
   rd_t ent;
   int  m_mem [WTS_RAM_WORDS];
   bit  armed = 1'b0;
   int  cyc = 0;
   int  m_cnt = 0;
   int  m_who;
   int  m_a;
   bit  m_cpu_turn, m_prev_cpu, m_prev_snd;
   bit  e_cpu_ack, e_snd_ack, e_we, e_a_chk, e_d_chk, e_cpu_qv, e_snd_qv;
   int  e_a, e_d, e_cpu_q, e_snd_q;

   // Inputs change just after a rising edge, so at the falling edge they are
   // exactly what the next rising edge samples.
   always @(negedge clk) begin
      if (armed) begin
         chk("cpu_ack",     int'(bus_if.cpu_ack),     int'(e_cpu_ack));
         chk("snd_ack",     int'(bus_if.snd_ack),     int'(e_snd_ack));
         chk("sram_we",     int'(bus_if.sram_we),     int'(e_we));
         chk("cpu_q_valid", int'(bus_if.cpu_q_valid), int'(e_cpu_qv));
         chk("snd_q_valid", int'(bus_if.snd_q_valid), int'(e_snd_qv));
         chk("cpu_q",       int'(bus_if.cpu_q),       e_cpu_q);
         chk("snd_q",       int'(bus_if.snd_q),       e_snd_q);
         if (e_a_chk) chk("sram_a", int'(bus_if.sram_a), e_a);
         if (e_d_chk) chk("sram_d", int'(bus_if.sram_d), e_d);
      end
      m_prev_cpu = e_cpu_ack;
      m_prev_snd = e_snd_ack;
      cyc++;
      e_cpu_ack = 0; e_snd_ack = 0; e_we = 0; e_a_chk = 0; e_d_chk = 0;
      e_cpu_qv  = 0; e_snd_qv  = 0;
      if (!nreset) begin
         armed   = 1'b1;
         rdq.delete();
         m_cnt   = 0;
         e_cpu_q = 0;
         e_snd_q = 0;
         e_a_chk = 1; e_a = 0;
         e_d_chk = 1; e_d = 0;
      end else begin
         m_cpu_turn = bus_if.cpu_req && (m_cnt == BURST);
         m_who = 0;
         if (bus_if.snd_req && !m_cpu_turn) m_who = m_prev_snd ? 0 : 1;
         else if (bus_if.cpu_req && !m_prev_cpu) m_who = 2;
         if (!bus_if.cpu_req || m_who == 2) m_cnt = 0;
         else if (m_who == 1) m_cnt++;
         if (m_who == 2) begin
            e_cpu_ack = 1;
            m_a = int'(bus_if.cpu_a);
            if (bus_if.cpu_wr) begin
               if (m_a < WTS_RAM_WORDS) begin
                  e_we = 1; e_a_chk = 1; e_a = m_a; e_d_chk = 1; e_d = int'(bus_if.cpu_d);
                  m_mem[m_a] = int'(bus_if.cpu_d);
               end
            end else if (m_a < WTS_RAM_WORDS) begin
               e_a_chk = 1; e_a = m_a;
               rdq.push_back('{cyc + 2, 1'b0, m_mem[m_a]});
            end else begin
               rdq.push_back('{cyc + 2, 1'b0, 255});
            end
         end else if (m_who == 1) begin
            e_snd_ack = 1;
            if (int'(bus_if.snd_ch) < WTS_CH_NUM) begin
               m_a = int'(bus_if.snd_ch) * WTS_WAVE_LEN + int'(bus_if.snd_idx);
               e_a_chk = 1; e_a = m_a;
               rdq.push_back('{cyc + 2, 1'b1, m_mem[m_a]});
            end else begin
               rdq.push_back('{cyc + 2, 1'b1, 0});
            end
         end
         while (rdq.size() > 0 && rdq[0].due == cyc) begin
            ent = rdq.pop_front();
            if (ent.snd) begin e_snd_qv = 1; e_snd_q = ent.data; end
            else         begin e_cpu_qv = 1; e_cpu_q = ent.data; end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_op(input bit wr, input int a, input int d);
      int n = 0;
      bus_if.cpu_req = 1'b1;
      bus_if.cpu_wr  = wr;
      bus_if.cpu_a   = 9'(a);
      bus_if.cpu_d   = 8'(d);
      do begin tick(); n++; end while (!bus_if.cpu_ack && n < 50);
      if (!bus_if.cpu_ack) chk("cpu_ack_timeout", 0, 1);
      bus_if.cpu_req = 1'b0;
   endtask

   task automatic snd_op(input int ch, input int idx);
      int n = 0;
      bus_if.snd_req = 1'b1;
      bus_if.snd_ch  = 4'(ch);
      bus_if.snd_idx = 5'(idx);
      do begin tick(); n++; end while (!bus_if.snd_ack && n < 50);
      if (!bus_if.snd_ack) chk("snd_ack_timeout", 0, 1);
      bus_if.snd_req = 1'b0;
   endtask

   int g [$];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus_if.cpu_req = 0; bus_if.cpu_wr = 0; bus_if.cpu_a = '0; bus_if.cpu_d = '0;
      bus_if.snd_req = 0; bus_if.snd_ch = '0; bus_if.snd_idx = '0;
      for (int i = 0; i < 512; i++) ram[i] = 8'h00;
      for (int i = 0; i < WTS_RAM_WORDS; i++) m_mem[i] = 0;

      nreset = 1'b0;
      repeat (3) tick();
      chk("rst_cpu_ack", int'(bus_if.cpu_ack), 0);
      chk("rst_sram_we", int'(bus_if.sram_we), 0);
      chk("rst_sram_a",  int'(bus_if.sram_a),  0);
      chk("rst_cpu_q",   int'(bus_if.cpu_q),   0);
      nreset = 1'b1;
      tick();

      for (int i = 0; i < WTS_RAM_WORDS; i++) cpu_op(1'b1, i, (i + 100) & 255);

      for (int i = 0; i < WTS_RAM_WORDS; i++) begin
         cpu_op(1'b0, i, 0);
         tick();
         chk("rd_valid_early", int'(bus_if.cpu_q_valid), 0);
         tick();
         chk("rd_valid_n2", int'(bus_if.cpu_q_valid), 1);
         chk("rd_data", int'(bus_if.cpu_q), (i + 100) & 255);
      end

      snd_op(3, 5);
      chk("snd_addr_3_5", int'(bus_if.sram_a), 101);
      chk("snd_we_3_5", int'(bus_if.sram_we), 0);
      repeat (2) tick();
      chk("snd_valid_3_5", int'(bus_if.snd_q_valid), 1);
      chk("snd_q_3_5", int'(bus_if.snd_q), 8'hC9);

      snd_op(13, 4);
      chk("snd_we_ch13", int'(bus_if.sram_we), 0);
      repeat (2) tick();
      chk("snd_valid_ch13", int'(bus_if.snd_q_valid), 1);
      chk("snd_q_ch13", int'(bus_if.snd_q), 0);

      cpu_op(1'b1, 'h180, 'h55);
      chk("oor_wr_we", int'(bus_if.sram_we), 0);
      tick();
      chk("oor_wr_we_next", int'(bus_if.sram_we), 0);
      cpu_op(1'b0, 'h1FF, 0);
      repeat (2) tick();
      chk("oor_rd_valid", int'(bus_if.cpu_q_valid), 1);
      chk("oor_rd_q", int'(bus_if.cpu_q), 8'hFF);
      repeat (2) tick();

      bus_if.cpu_req = 1; bus_if.cpu_wr = 0; bus_if.cpu_a = 9'd7;
      bus_if.snd_req = 1; bus_if.snd_ch = 4'd1; bus_if.snd_idx = 5'd2;
      for (int k = 0; k < 24; k++) begin
         tick();
         chk("ack_overlap", int'(bus_if.cpu_ack && bus_if.snd_ack), 0);
         if (bus_if.snd_ack) g.push_back(1);
         if (bus_if.cpu_ack) g.push_back(2);
      end
      bus_if.cpu_req = 0; bus_if.snd_req = 0;
      chk("burst_grants_enough", int'(g.size() >= 9), 1);
      for (int k = 0; k < 9 && k < g.size(); k++)
         chk("burst_pattern", g[k], (k % 3 == 2) ? 2 : 1);
      repeat (4) tick();

      fork
         begin
            for (int kc = 0; kc < 1500; kc++) begin
               tick();
               if (!bus_if.cpu_req || bus_if.cpu_ack) begin
                  bus_if.cpu_req = ($urandom_range(0, 3) != 0);
                  bus_if.cpu_wr  = ($urandom_range(0, 1) == 1);
                  bus_if.cpu_a   = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(384, 511))
                                                               : 9'($urandom_range(0, 383));
                  bus_if.cpu_d   = 8'($urandom_range(0, 255));
               end
            end
         end
         begin
            for (int ks = 0; ks < 1500; ks++) begin
               tick();
               if (!bus_if.snd_req || bus_if.snd_ack) begin
                  bus_if.snd_req = ($urandom_range(0, 3) != 0);
                  bus_if.snd_ch  = 4'($urandom_range(0, 15));
                  bus_if.snd_idx = 5'($urandom_range(0, 31));
               end
            end
         end
      join
      bus_if.cpu_req = 0; bus_if.snd_req = 0;
      repeat (4) tick();

      cpu_op(1'b0, 20, 0);
      nreset = 1'b0;
      tick();
      chk("rst2_cpu_ack",  int'(bus_if.cpu_ack),     0);
      chk("rst2_snd_ack",  int'(bus_if.snd_ack),     0);
      chk("rst2_sram_we",  int'(bus_if.sram_we),     0);
      chk("rst2_sram_a",   int'(bus_if.sram_a),      0);
      chk("rst2_sram_d",   int'(bus_if.sram_d),      0);
      chk("rst2_cpu_q",    int'(bus_if.cpu_q),       0);
      chk("rst2_snd_q",    int'(bus_if.snd_q),       0);
      chk("rst2_cpu_qv",   int'(bus_if.cpu_q_valid), 0);
      chk("rst2_snd_qv",   int'(bus_if.snd_q_valid), 0);
      nreset = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("rst2_no_qvalid", int'(bus_if.cpu_q_valid || bus_if.snd_q_valid), 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
